x8_radix_converter: RTL
=======================

// Module: x8_radix_converter
// PURPOSE
//  Iterative signed binary-to-radix digit converter between the processor output and the
//  8-digit seven-segment display driver. Takes a 32-bit two's-complement value and a radix,
//  and produces 8 digit codes (LS digit first), a sign flag, and a leading-zero blank mask.
//  Digits come from restoring long division, one quotient bit per clock.
// PARAMETERS
//  WIDTH   32  data width of value / magnitude
//  DIGITS  8   number of output digits (4 bits each)
// PORTS
//  clk      in   1          system clock; all state updates on posedge
//  rst      in   1          asynchronous, active-low reset
//  start    in   1          request conversion; sampled only in IDLE
//  value    in   WIDTH      signed input value, captured when start is accepted
//  radix    in   5          base; legal range 2..16, captured when start is accepted
//  busy     out  1          high from the cycle after acceptance until done
//  done     out  1          one-cycle pulse when the outputs update
//  digits   out  4*DIGITS   digit[i] = digits[4i+3:4i]; digit 0 is least significant
//  blank    out  DIGITS     1 = leading-zero position; blank[0] is always 0
//  neg      out  1          input was negative
//  ovf      out  1          magnitude needs more than DIGITS digits; low DIGITS digits shown
//  err      out  1          radix outside 2..16
// BEHAVIOUR
//  - Reset (rst=0, asynchronous) clears all outputs and internal registers; the FSM goes to IDLE.
//  - FSM states:
//    - IDLE: when start=1, capture neg=value[WIDTH-1], mag=|value|, and radix.
//      Legal radix -> DIV; illegal radix -> FIN with the error path.
//    - DIV: WIDTH cycles per digit. Each cycle: rem = {rem,q[MSB]}, shift q left.
//      If rem >= radix: rem -= radix and shift in 1, else shift in 0.
//      rem is 6 bits wide and rem < radix <= 16 always holds.
//    - STORE: 1 cycle. rem goes to digit slot d, q becomes the new dividend, rem clears,
//      d increments. Continue to DIV if d < DIGITS-1, else go to FIN.
//    - FIN: 1 cycle. Output registers load atomically, done=1, then return to IDLE.
//  - Magnitude: |value| is unsigned over WIDTH bits, so 0x80000000 gives mag 0x80000000
//    with no special case.
//  - Latency: done pulses exactly 1 + DIGITS*(WIDTH+1) cycles after the accepting edge
//    (265 for defaults). Latency is fixed and there is no early exit on a zero dividend.
//  - Error path: done pulses 1 cycle after acceptance with err=1 and digits=0, blank=0xFE,
//    neg=0, ovf=0.
//  - ovf = 1 when the dividend is nonzero after the final STORE.
//  - blank[i] = 1 when every digit j >= i is 0, for i >= 1. It is computed in FIN.
//  - Outputs hold between completions. err/ovf/neg refresh on every done.
//  - busy = 1 in DIV and STORE. It is 0 in IDLE and FIN. start is ignored while not in IDLE.
//  - start asserted in the same cycle as FIN is not accepted; it must be held to IDLE.
//  - Reset mid-conversion aborts immediately, with no done pulse and cleared outputs.
// STRUCTURE
//  - Shared package: DIGITS, DIGIT_W=4, RADIX_MIN=2, RADIX_MAX=16, FSM state encoding
//    (IDLE, DIV, STORE, FIN).
//  - Sub-module radix_div_step: combinational one-bit restoring step
//    (rem_in, q_msb, radix -> rem_out, qbit).
//  - The top holds the FSM, bit counter (log2 WIDTH), digit counter, shift registers,
//    and output registers.
// TESTING
//  1. value=255, radix=16 -> digits=0x000000FF, blank=0xFC, neg=0, ovf=0, done at +265.
//  2. value=-1234, radix=10 -> digits=0x00001234, blank=0xF0, neg=1, ovf=0.
//  3. value=0x80000000, radix=16 -> digits=0x80000000, blank=0x00, neg=1, ovf=0;
//     value=0, radix=7 -> digits=0, blank=0xFE.
//  4. value=0x7FFFFFFF, radix=2 -> digits=0x11111111, blank=0x00, ovf=1.
//  5. radix=1 and radix=17 -> err=1, digits=0, done one cycle after start.
//     Then radix=10, value=9 -> err clears, digits=0x9.
//  6. start pulsed at +100 while busy -> ignored, single done at +265;
//     rst low at +50 -> outputs 0, busy=0, no done pulse.

Source files
------------

// File: rtl/x8_radix_converter_pkg.sv
// Shared constants, FSM encoding and the leading-zero mask helper for the
// x8 radix converter.
package x8_radix_converter_pkg;

  localparam int DIGITS    = 8;
  localparam int DIGIT_W   = 4;
  localparam int RADIX_MIN = 2;
  localparam int RADIX_MAX = 16;
  localparam int REM_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_STORE = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // blank[i] is set when digit i and every digit above it are zero; digit 0 is never blanked.
  function automatic logic [DIGITS-1:0] leading_blank(input logic [DIGITS*DIGIT_W-1:0] dig);
    logic [DIGITS-1:0] mask;
    logic              zero_above;
    mask       = {DIGITS{1'b0}};
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (dig[i*DIGIT_W +: DIGIT_W] == {DIGIT_W{1'b0}});
      mask[i]    = zero_above;
    end
    return mask;
  endfunction

endpackage

// File: rtl/x8_radix_converter_div_step.sv
// One bit of restoring division: shift the next dividend bit into the
// remainder and subtract the radix when it fits.
module radix_div_step
  import x8_radix_converter_pkg::*;
(
  input  logic [REM_W-1:0] rem_in,
  input  logic             q_msb,
  input  logic [4:0]       radix,
  output logic [REM_W-1:0] rem_out,
  output logic             qbit
);

  logic [REM_W:0]   shifted_s;
  logic [REM_W-1:0] diff_s;

  // Trial subtraction; the remainder stays below the radix so the low bits hold the result.
  always_comb begin
    shifted_s = {rem_in, q_msb};
    diff_s    = shifted_s[REM_W-1:0] - {1'b0, radix};
    if (shifted_s >= {2'b00, radix}) begin
      rem_out = diff_s;
      qbit    = 1'b1;
    end else begin
      rem_out = shifted_s[REM_W-1:0];
      qbit    = 1'b0;
    end
  end

endmodule

// File: rtl/x8_radix_converter.sv
// Signed binary to radix-2..16 digit converter: one quotient bit per clock,
// eight digits LS first, with sign, overflow, error and leading-zero mask.
module x8_radix_converter
  import x8_radix_converter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          value,
  input  logic [4:0]                radix,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] digits,
  output logic [DIGITS-1:0]         blank,
  output logic                      neg,
  output logic                      ovf,
  output logic                      err
);

  localparam int CNT_W  = $clog2(WIDTH);
  localparam int DCNT_W = $clog2(DIGITS);

  state_e                    state_r, state_s;
  logic [WIDTH-1:0]          q_r;
  logic [REM_W-1:0]          rem_r;
  logic [4:0]                radix_r;
  logic                      neg_cap_r, err_cap_r;
  logic [CNT_W-1:0]          bit_cnt_r;
  logic [DCNT_W-1:0]         dcnt_r;
  logic [DIGIT_W*DIGITS-1:0] work_r;
  logic                      busy_r, done_r, neg_r, ovf_r, err_r;
  logic [DIGIT_W*DIGITS-1:0] digits_r;
  logic [DIGITS-1:0]         blank_r;
  logic [REM_W-1:0]          step_rem_s;
  logic                      step_qbit_s;
  logic                      radix_ok_s;

  radix_div_step u_step (
    .rem_in  (rem_r),
    .q_msb   (q_r[WIDTH-1]),
    .radix   (radix_r),
    .rem_out (step_rem_s),
    .qbit    (step_qbit_s)
  );

  // Next-state logic.
  always_comb begin
    state_s    = state_r;
    radix_ok_s = (radix >= 5'(RADIX_MIN)) && (radix <= 5'(RADIX_MAX));
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = radix_ok_s ? ST_DIV : ST_FIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (bit_cnt_r == CNT_W'(WIDTH - 1)) begin
          state_s = ST_STORE;
        end else begin
          state_s = ST_DIV;
        end
      end
      ST_STORE: begin
        if (dcnt_r == DCNT_W'(DIGITS - 1)) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_DIV;
        end
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; outputs change only in FIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      q_r       <= {WIDTH{1'b0}};
      rem_r     <= {REM_W{1'b0}};
      radix_r   <= 5'd0;
      neg_cap_r <= 1'b0;
      err_cap_r <= 1'b0;
      bit_cnt_r <= {CNT_W{1'b0}};
      dcnt_r    <= {DCNT_W{1'b0}};
      work_r    <= {(DIGIT_W*DIGITS){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      neg_r     <= 1'b0;
      ovf_r     <= 1'b0;
      err_r     <= 1'b0;
      digits_r  <= {(DIGIT_W*DIGITS){1'b0}};
      blank_r   <= {DIGITS{1'b0}};
    end else begin
      state_r <= state_s;
      done_r  <= 1'b0;
      busy_r  <= (state_s == ST_DIV) || (state_s == ST_STORE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            neg_cap_r <= value[WIDTH-1];
            // Unsigned negation: the most negative input maps to itself.
            q_r       <= value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
            radix_r   <= radix;
            err_cap_r <= ~radix_ok_s;
            rem_r     <= {REM_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            dcnt_r    <= {DCNT_W{1'b0}};
            work_r    <= {(DIGIT_W*DIGITS){1'b0}};
          end
        end
        ST_DIV: begin
          rem_r     <= step_rem_s;
          q_r       <= {q_r[WIDTH-2:0], step_qbit_s};
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end
        ST_STORE: begin
          work_r[dcnt_r*DIGIT_W +: DIGIT_W] <= rem_r[DIGIT_W-1:0];
          rem_r     <= {REM_W{1'b0}};
          dcnt_r    <= dcnt_r + DCNT_W'(1);
          bit_cnt_r <= {CNT_W{1'b0}};
        end
        ST_FIN: begin
          done_r <= 1'b1;
          if (err_cap_r) begin
            digits_r <= {(DIGIT_W*DIGITS){1'b0}};
            blank_r  <= {{(DIGITS-1){1'b1}}, 1'b0};
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
            err_r    <= 1'b1;
          end else begin
            digits_r <= work_r;
            blank_r  <= leading_blank(work_r);
            neg_r    <= neg_cap_r;
            ovf_r    <= (q_r != {WIDTH{1'b0}});
            err_r    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign digits = digits_r;
  assign blank  = blank_r;
  assign neg    = neg_r;
  assign ovf    = ovf_r;
  assign err    = err_r;

endmodule
